// File: rtl/output_interface.sv
// output_interface: unloads a captured 1600-bit Keccak state as a sequence
// of 200-bit chunks (dox = 0..NCHUNKS-1) under downstream backpressure.
// Optional feature: define OUTPUT_PARITY_EN to add the doutpar port, the
// XOR of all dout bits.
// The state is captured only when the block is not busy. A new state may be
// captured in the same cycle the final chunk transfers, giving gapless
// back-to-back unloads.
module output_interface #(
    parameter int NCHUNKS = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pushin,
    input  logic [1599:0] din,
    output logic          busy,
    output logic          pushout,
    input  logic          stopout,
    output logic [2:0]    dox,
    output logic [199:0]  dout
`ifdef OUTPUT_PARITY_EN
    ,
    output logic          doutpar
`endif
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    localparam logic [2:0] LAST_DOX = 3'(NCHUNKS - 1);

    state_t        r_state;
    state_t        w_nextState;
    logic [1599:0] r_data;
    logic [1599:0] w_nextData;
    logic [2:0]    r_dox;
    logic [2:0]    w_nextDox;

    logic          w_sending;
    logic          w_lastChunk;
    logic          w_transfer;
    logic          w_busy;
    logic          w_capture;
    logic [10:0]   w_chunkBase;

    // Handshake decode: a chunk moves when presented and not stalled; the
    // block frees up only on the cycle its final chunk leaves.
    always_comb begin
        w_sending   = (r_state == SEND);
        w_lastChunk = (r_dox == LAST_DOX);
        w_transfer  = w_sending && !stopout;
        w_busy      = w_sending && !(w_transfer && w_lastChunk);
        w_capture   = pushin && !w_busy;
    end

    // Next-state logic: a capture always restarts at chunk 0 (even while the
    // final chunk of the previous state leaves); otherwise step on transfers.
    always_comb begin
        w_nextState = r_state;
        w_nextData  = r_data;
        w_nextDox   = r_dox;
        if (w_capture) begin
            w_nextState = SEND;
            w_nextData  = din;
            w_nextDox   = 3'd0;
        end else if (w_transfer) begin
            if (w_lastChunk) begin
                w_nextState = IDLE;
                w_nextDox   = 3'd0;
            end else begin
                w_nextDox = r_dox + 3'd1;
            end
        end
    end

    // State, captured data and chunk index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_dox   <= 3'd0;
        end else begin
            r_state <= w_nextState;
            r_data  <= w_nextData;
            r_dox   <= w_nextDox;
        end
    end

    // Output selection: dout is a pure mux of registered state, so it only
    // moves when dox or the captured data moves.
    always_comb begin
        w_chunkBase = 11'(r_dox) * 11'd200;
        busy        = w_busy;
        pushout     = w_sending;
        dox         = r_dox;
        dout        = r_data[w_chunkBase +: 200];
    end

`ifdef OUTPUT_PARITY_EN
    // Parity over the presented chunk; zero after reset since dout is zero.
    always_comb begin
        doutpar = ^dout;
    end
`endif

endmodule

// File: tb/tb_output_interface.sv
// tb_output_interface: directed scoreboard bench for output_interface.
// Instance dutA uses NCHUNKS=8, dutB uses NCHUNKS=2 for truncation checks.
module tb_output_interface;

    typedef struct packed {
        logic [2:0]   dox;
        logic [199:0] dout;
        logic         par;
    } expChunk_t;

    logic          clk;
    logic          reset;

    logic          pushinA, stopoutA, busyA, pushoutA;
    logic [1599:0] dinA;
    logic [2:0]    doxA;
    logic [199:0]  doutA;

    logic          pushinB, stopoutB, busyB, pushoutB;
    logic [1599:0] dinB;
    logic [2:0]    doxB;
    logic [199:0]  doutB;

`ifdef OUTPUT_PARITY_EN
    logic          parA, parB;
`endif

    expChunk_t     qA[$];
    expChunk_t     qB[$];
    int            checks   = 0;
    int            failures = 0;
    int            xfersA   = 0;
    int            xfersB   = 0;

    output_interface #(.NCHUNKS(8)) dutA (
        .clk(clk), .reset(reset), .pushin(pushinA), .din(dinA),
        .busy(busyA), .pushout(pushoutA), .stopout(stopoutA),
        .dox(doxA), .dout(doutA)
`ifdef OUTPUT_PARITY_EN
        , .doutpar(parA)
`endif
    );

    output_interface #(.NCHUNKS(2)) dutB (
        .clk(clk), .reset(reset), .pushin(pushinB), .din(dinB),
        .busy(busyB), .pushout(pushoutB), .stopout(stopoutB),
        .dox(doxB), .dout(doutB)
`ifdef OUTPUT_PARITY_EN
        , .doutpar(parB)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [255:0] obs,
                               input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue the chunks a capture of d is expected to produce.
    task automatic pushExpected(input bit sel, input logic [1599:0] d, input int n);
        expChunk_t e;
        for (int i = 0; i < n; i++) begin
            e.dox  = 3'(i);
            e.dout = d[200*i +: 200];
            e.par  = ^e.dout;
            if (sel) qB.push_back(e);
            else     qA.push_back(e);
        end
    endtask

    // Scoreboard: every observed transfer must match the head of its queue.
    task automatic scoreboardCheck();
        expChunk_t e;
        if (pushoutA === 1'b1 && stopoutA === 1'b0) begin
            xfersA++;
            if (qA.size() == 0) begin
                checkOutput("A_extra_chunk", 256'(pushoutA), 256'd0);
            end else begin
                e = qA.pop_front();
                checkOutput("A_dox", 256'(doxA), 256'(e.dox));
                checkOutput("A_dout", 256'(doutA), 256'(e.dout));
`ifdef OUTPUT_PARITY_EN
                checkOutput("A_par", 256'(parA), 256'(e.par));
`endif
            end
        end
        if (pushoutB === 1'b1 && stopoutB === 1'b0) begin
            xfersB++;
            if (qB.size() == 0) begin
                checkOutput("B_extra_chunk", 256'(pushoutB), 256'd0);
            end else begin
                e = qB.pop_front();
                checkOutput("B_dox", 256'(doxB), 256'(e.dox));
                checkOutput("B_dout", 256'(doutB), 256'(e.dout));
`ifdef OUTPUT_PARITY_EN
                checkOutput("B_par", 256'(parB), 256'(e.par));
`endif
            end
        end
    endtask

    // One clock: sample transfers mid-cycle, then move just past the edge.
    task automatic applyStimulus();
        @(negedge clk);
        scoreboardCheck();
        @(posedge clk);
        #1;
    endtask

    // Run clocks until the selected queue drains, with a cycle bound.
    task automatic drain(input bit sel, output int n);
        n = 0;
        while (((sel ? qB.size() : qA.size()) > 0) && n < 40) begin
            applyStimulus();
            n++;
        end
        if ((sel ? qB.size() : qA.size()) > 0)
            checkOutput("drain_timeout", 256'(sel ? qB.size() : qA.size()), 256'd0);
    endtask

    function automatic logic [1599:0] randomState();
        logic [1599:0] d;
        for (int i = 0; i < 50; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Directed sequence covering reset, unload, backpressure, back-to-back,
    // ignored push, reset mid-send and truncation.
    initial begin
        int            n;
        int            startX;
        logic [199:0]  held;
        logic [1599:0] s1, s2;

        reset = 1'b0; pushinA = 1'b0; stopoutA = 1'b0; dinA = '0;
        pushinB = 1'b0; stopoutB = 1'b0; dinB = '0;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_pushout", 256'(pushoutA), 256'd0);
        checkOutput("rst_dox", 256'(doxA), 256'd0);
        checkOutput("rst_dout", 256'(doutA), 256'd0);
        checkOutput("rst_busy", 256'(busyA), 256'd0);
`ifdef OUTPUT_PARITY_EN
        checkOutput("rst_par", 256'(parA), 256'd0);
`endif
        reset = 1'b1;
        applyStimulus();

        // Basic unload.
        dinA = '0;
        dinA[63:0] = 64'h0123456789ABCDEF;
        pushinA = 1'b1;
        #1 checkOutput("basic_busy_idle", 256'(busyA), 256'd0);
        pushExpected(1'b0, dinA, 8);
        applyStimulus();
        pushinA = 1'b0;
        #1;
        checkOutput("basic_pushout", 256'(pushoutA), 256'd1);
        checkOutput("basic_dox0", 256'(doxA), 256'd0);
        checkOutput("basic_lane00", 256'(doutA[63:0]), 256'h0123456789ABCDEF);
        drain(1'b0, n);
        checkOutput("basic_cycles", 256'(n), 256'd8);
        checkOutput("basic_idle", 256'(pushoutA), 256'd0);

        // Backpressure at dox=2.
        s1 = randomState();
        dinA = s1; pushinA = 1'b1;
        pushExpected(1'b0, s1, 8);
        startX = xfersA;
        applyStimulus();
        pushinA = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("bp_dox2", 256'(doxA), 256'd2);
        held = doutA;
        stopoutA = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bp_hold_dox", 256'(doxA), 256'd2);
            checkOutput("bp_hold_dout", 256'(doutA), 256'(held));
            checkOutput("bp_hold_busy", 256'(busyA), 256'd1);
            applyStimulus();
        end
        stopoutA = 1'b0;
        #1;
        checkOutput("bp_4th_dox", 256'(doxA), 256'd2);
        checkOutput("bp_4th_dout", 256'(doutA), 256'(held));
        applyStimulus();
        checkOutput("bp_dox3", 256'(doxA), 256'd3);
        drain(1'b0, n);
        checkOutput("bp_total", 256'(xfersA - startX), 256'd8);

        // Back-to-back capture on the final transfer.
        s1 = randomState();
        s2 = randomState();
        dinA = s1; pushinA = 1'b1;
        pushExpected(1'b0, s1, 8);
        applyStimulus();
        pushinA = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus();
        checkOutput("b2b_dox7", 256'(doxA), 256'd7);
        dinA = s2; pushinA = 1'b1;
        #1 checkOutput("b2b_busy_last", 256'(busyA), 256'd0);
        pushExpected(1'b0, s2, 8);
        applyStimulus();
        pushinA = 1'b0;
        checkOutput("b2b_pushout", 256'(pushoutA), 256'd1);
        checkOutput("b2b_dox0", 256'(doxA), 256'd0);
        checkOutput("b2b_dout0", 256'(doutA), 256'(s2[199:0]));
        drain(1'b0, n);
        checkOutput("b2b_cycles", 256'(n), 256'd8);

        // Ignored push at dox=4.
        s1 = randomState();
        dinA = s1; pushinA = 1'b1;
        pushExpected(1'b0, s1, 8);
        applyStimulus();
        pushinA = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        checkOutput("ign_dox4", 256'(doxA), 256'd4);
        dinA = ~s1; pushinA = 1'b1;
        #1 checkOutput("ign_busy", 256'(busyA), 256'd1);
        applyStimulus();
        pushinA = 1'b0;
        drain(1'b0, n);
        checkOutput("ign_cycles", 256'(n), 256'd3);
        applyStimulus();
        checkOutput("ign_idle", 256'(pushoutA), 256'd0);

        // Reset mid-send at dox=5, with a push that must be ignored.
        s1 = randomState();
        dinA = s1; pushinA = 1'b1;
        pushExpected(1'b0, s1, 8);
        applyStimulus();
        pushinA = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("rms_dox5", 256'(doxA), 256'd5);
        reset = 1'b0; pushinA = 1'b1;
        applyStimulus();
        qA.delete();
        pushinA = 1'b0;
        checkOutput("rms_pushout", 256'(pushoutA), 256'd0);
        checkOutput("rms_dox", 256'(doxA), 256'd0);
        checkOutput("rms_dout", 256'(doutA), 256'd0);
        checkOutput("rms_busy", 256'(busyA), 256'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("rms_no_resume", 256'(pushoutA), 256'd0);

        // Truncation on the NCHUNKS=2 instance, all-ones state.
        dinB = '1; pushinB = 1'b1;
        #1 checkOutput("trunc_busy", 256'(busyB), 256'd0);
        pushExpected(1'b1, dinB, 2);
        startX = xfersB;
        applyStimulus();
        pushinB = 1'b0;
        drain(1'b1, n);
        checkOutput("trunc_cycles", 256'(n), 256'd2);
        applyStimulus();
        applyStimulus();
        checkOutput("trunc_idle", 256'(pushoutB), 256'd0);
        checkOutput("trunc_total", 256'(xfersB - startX), 256'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
